// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory bus responder.
//   mb_state_t    : responder FSM state encoding (IDLE=0, WAIT=1, RESP=2)
//   MB_BITS_DATA  : default data word width
//   MB_BITS_ADDR  : default bus address width
//   MB_CNT_W      : width of the wait-state counter (WAIT_STATES range 0..255)
package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_WAIT = 2'd1,
    MB_RESP = 2'd2
  } mb_state_t;

  localparam int MB_BITS_DATA = 32;
  localparam int MB_BITS_ADDR = 16;
  localparam int MB_CNT_W     = 8;

endpackage

// File: rtl/mem_bus_responder_mem_array_sp.sv
// mem_array_sp: single-port synchronous word array.
//   Write and read both happen on posedge clk; the read returns the contents
//   before any write on the same edge (read-before-write). Contents are never reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   addr   in  [AW-1:0] word index
//   wdata  in  [DW-1:0] write data
//   rdata  out [DW-1:0] registered read data
module mem_array_sp #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: responder end of the CPU memory bus.
//   Captures a single-cycle request, waits WAIT_STATES cycles, then performs the
//   read or write on internal storage and pulses ack for one cycle.
// Optional feature: define MEM_RANGE_CHECK_EN to restrict accesses to the window
//   BASE_ADDR .. BASE_ADDR+2^DEPTH_BITS-1 (no wrap); out-of-window accesses are
//   suppressed (reads return 0) and flagged with err alongside ack. Without the
//   macro every address aliases modulo 2^DEPTH_BITS and err stays 0.
// Ports:
//   clk    in  clock, all state on posedge
//   reset  in  asynchronous active-low reset
//   req    in  request strobe, sampled only in IDLE
//   MAR    in  [BITS_ADDR-1:0] request address, sampled with req
//   MBR_W  in  [BITS_DATA-1:0] write data, sampled with req
//   write  in  1 = write, 0 = read, sampled with req
//   MBR_R  out [BITS_DATA-1:0] read data, held until the next read ack
//   ack    out one-cycle completion pulse
//   busy   out high from the capture edge through the ack cycle
//   err    out out-of-window flag, coincident with ack
// DEPTH_BITS must not exceed BITS_ADDR.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int BITS_DATA   = MB_BITS_DATA,
  parameter int BITS_ADDR   = MB_BITS_ADDR,
  parameter int DEPTH_BITS  = 10,
  parameter int WAIT_STATES = 2,
  parameter int BASE_ADDR   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [BITS_ADDR-1:0] MAR,
  input  logic [BITS_DATA-1:0] MBR_W,
  input  logic                 write,
  output logic [BITS_DATA-1:0] MBR_R,
  output logic                 ack,
  output logic                 busy,
  output logic                 err
);

  localparam logic [MB_CNT_W-1:0]  WS_INIT = MB_CNT_W'(WAIT_STATES);
  localparam logic [BITS_ADDR-1:0] BASE    = BITS_ADDR'(BASE_ADDR);

  mb_state_t state, state_nxt;
  logic [MB_CNT_W-1:0]   cnt, cnt_nxt;
  logic                  ack_nxt, busy_nxt, err_nxt;
  logic [BITS_DATA-1:0]  mbr_r_nxt;

  logic [BITS_ADDR-1:0]  mar_lat;
  logic [BITS_DATA-1:0]  wdata_lat;
  logic                  write_lat;

  logic                  mem_we;
  logic [DEPTH_BITS-1:0] mem_addr;
  logic [BITS_DATA-1:0]  mem_rdata;
  logic                  in_range;

  // The array reads every cycle. In IDLE its address follows the live MAR so
  // that the word is already read on the capture edge; this keeps read data
  // ready at the access edge even with zero wait states.
  always_comb begin
    if (state == MB_IDLE) begin
      mem_addr = DEPTH_BITS'(MAR - BASE);
    end else begin
      mem_addr = DEPTH_BITS'(mar_lat - BASE);
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic [BITS_ADDR:0] span;
  // One extra bit so the offset cannot wrap past the top of the address space.
  assign span     = {1'b0, mar_lat} - {1'b0, BASE};
  assign in_range = (mar_lat >= BASE) && ((span >> DEPTH_BITS) == '0);
`else
  assign in_range = 1'b1;
`endif

  mem_array_sp #(
    .DW (BITS_DATA),
    .AW (DEPTH_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_lat),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    busy_nxt  = busy;
    err_nxt   = 1'b0;
    mbr_r_nxt = MBR_R;
    mem_we    = 1'b0;
    case (state)
      MB_IDLE: begin
        if (req) begin
          cnt_nxt   = WS_INIT;
          busy_nxt  = 1'b1;
          state_nxt = MB_WAIT;
        end
      end
      MB_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          ack_nxt   = 1'b1;
          err_nxt   = ~in_range;
          state_nxt = MB_RESP;
          if (write_lat) begin
            mem_we = in_range;
          end else begin
            mbr_r_nxt = in_range ? mem_rdata : '0;
          end
        end
      end
      MB_RESP: begin
        busy_nxt  = 1'b0;
        state_nxt = MB_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = MB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MB_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      MBR_R <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
      busy  <= busy_nxt;
      err   <= err_nxt;
      MBR_R <= mbr_r_nxt;
    end
  end

  // Request latches: pure data, captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == MB_IDLE && req) begin
      mar_lat   <= MAR;
      wdata_lat <= MBR_W;
      write_lat <= write;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder.
// Instance a: WAIT_STATES=2, BASE_ADDR=0. Instance b: WAIT_STATES=0.
// Instance c (only with MEM_RANGE_CHECK_EN): WAIT_STATES=2, BASE_ADDR=0x1000.
// Inputs are shared; sel routes req to one instance and picks its outputs.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [15:0] MAR;
  logic [31:0] MBR_W;
  logic        write;
  int          sel;

  logic [31:0] r_a, r_b, r_c;
  logic        ack_a, ack_b, ack_c, busy_a, busy_b, busy_c, err_a, err_b, err_c;
  logic [31:0] r_s;
  logic        ack_s, busy_s, err_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH_BITS(10),
                      .WAIT_STATES(2), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .reset(reset), .req(req && sel == 0), .MAR(MAR), .MBR_W(MBR_W),
    .write(write), .MBR_R(r_a), .ack(ack_a), .busy(busy_a), .err(err_a));

  mem_bus_responder #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH_BITS(10),
                      .WAIT_STATES(0), .BASE_ADDR(0)) u_dut_b (
    .clk(clk), .reset(reset), .req(req && sel == 1), .MAR(MAR), .MBR_W(MBR_W),
    .write(write), .MBR_R(r_b), .ack(ack_b), .busy(busy_b), .err(err_b));

`ifdef MEM_RANGE_CHECK_EN
  mem_bus_responder #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH_BITS(10),
                      .WAIT_STATES(2), .BASE_ADDR(16'h1000)) u_dut_c (
    .clk(clk), .reset(reset), .req(req && sel == 2), .MAR(MAR), .MBR_W(MBR_W),
    .write(write), .MBR_R(r_c), .ack(ack_c), .busy(busy_c), .err(err_c));
`else
  assign r_c = '0; assign ack_c = 1'b0; assign busy_c = 1'b0; assign err_c = 1'b0;
`endif

  always_comb begin
    case (sel)
      1:       begin r_s = r_b; ack_s = ack_b; busy_s = busy_b; err_s = err_b; end
      2:       begin r_s = r_c; ack_s = ack_c; busy_s = busy_c; err_s = err_c; end
      default: begin r_s = r_a; ack_s = ack_a; busy_s = busy_a; err_s = err_a; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance; after the capture edge the
  // bus fields are scrambled to show they are latched.
  task automatic xact(input string tag, input logic [15:0] addr, input logic [31:0] data,
                      input logic wr, input int exp_lat, input logic [31:0] exp_r,
                      input logic exp_err);
    int n;
    @(posedge clk); #1;
    req = 1'b1; MAR = addr; MBR_W = data; write = wr;
    @(posedge clk); #1;
    req = 1'b0; MAR = ~addr; MBR_W = ~data; write = ~wr;
    @(negedge clk);
    chk({tag, " busy_after_capture"}, 32'(busy_s), 32'd1);
    n = 0;
    while (!ack_s && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk({tag, " ack_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " MBR_R"}, r_s, exp_r);
    chk({tag, " err"}, 32'(err_s), 32'(exp_err));
    chk({tag, " busy_at_ack"}, 32'(busy_s), 32'd1);
    @(negedge clk);
    chk({tag, " ack_one_cycle"}, 32'(ack_s), 32'd0);
    chk({tag, " busy_done"}, 32'(busy_s), 32'd0);
    chk({tag, " MBR_R_held"}, r_s, exp_r);
  endtask

  initial begin
    int acks;
    reset = 1'b0; req = 1'b0; MAR = '0; MBR_W = '0; write = 1'b0; sel = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst MBR_R", r_a, 32'h0);
    chk("rst ack", 32'(ack_a), 32'd0);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst err", 32'(err_a), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Write then read back, 3-cycle latency
    xact("wr5", 16'h0005, 32'hDEADBEEF, 1'b1, 3, 32'h0, 1'b0);
    xact("rd5", 16'h0005, 32'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0);
    xact("wr9", 16'h0009, 32'h00001234, 1'b1, 3, 32'hDEADBEEF, 1'b0);

    // Request re-pulsed during WAIT is ignored
    @(posedge clk); #1;
    req = 1'b1; MAR = 16'h0020; MBR_W = 32'h00005555; write = 1'b1;
    @(posedge clk); #1;
    MAR = 16'h0009; MBR_W = 32'h00000BAD; write = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack_a) acks++;
      @(posedge clk);
    end
    chk("repulse ack_count", 32'(acks), 32'd1);
    xact("rd9", 16'h0009, 32'h0, 1'b0, 3, 32'h00001234, 1'b0);
    xact("rd20", 16'h0020, 32'h0, 1'b0, 3, 32'h00005555, 1'b0);

    // Reset in the middle of WAIT aborts the write
    xact("wr10", 16'h0010, 32'h00000077, 1'b1, 3, 32'h00005555, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; MAR = 16'h0010; MBR_W = 32'h0000FFFF; write = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("abort ack", 32'(ack_a), 32'd0);
    chk("abort busy", 32'(busy_a), 32'd0);
    chk("abort MBR_R", r_a, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_a) acks++;
      @(posedge clk);
    end
    chk("abort no_ack", 32'(acks), 32'd0);
    xact("rd10", 16'h0010, 32'h0, 1'b0, 3, 32'h00000077, 1'b0);

`ifndef MEM_RANGE_CHECK_EN
    // Aliasing modulo 2^DEPTH_BITS
    xact("wr403", 16'h0403, 32'h000000A5, 1'b1, 3, 32'h00000077, 1'b0);
    xact("rd003", 16'h0003, 32'h0, 1'b0, 3, 32'h000000A5, 1'b0);
`endif

    // Zero wait states
    sel = 1;
    xact("b_wr", 16'h0002, 32'h0BADF00D, 1'b1, 1, 32'h0, 1'b0);
    xact("b_rd", 16'h0002, 32'h0, 1'b0, 1, 32'h0BADF00D, 1'b0);

`ifdef MEM_RANGE_CHECK_EN
    // Window 0x1000..0x13FF
    sel = 2;
    xact("c_wr13ff", 16'h13FF, 32'h0000CAFE, 1'b1, 3, 32'h0, 1'b0);
    xact("c_rd13ff", 16'h13FF, 32'h0, 1'b0, 3, 32'h0000CAFE, 1'b0);
    xact("c_rd0fff", 16'h0FFF, 32'h0, 1'b0, 3, 32'h0, 1'b1);
    xact("c_wr1000", 16'h1000, 32'h00001111, 1'b1, 3, 32'h0, 1'b0);
    xact("c_wr1400", 16'h1400, 32'h0000BEEF, 1'b1, 3, 32'h0, 1'b1);
    xact("c_rd1000", 16'h1000, 32'h0, 1'b0, 3, 32'h00001111, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
